// File: rtl/spike_rate_monitor_pkg.sv
// Shared types, constants and the saturating-increment helper for the spike rate monitor.
package spike_mon_pkg;

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam int unsigned ISI_W = 8;
  localparam logic [ISI_W-1:0] ISI_MAX = 8'hFF;

  // Increment value, holding at 2**width-1 (width <= 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [32:0] max_val;
    max_val = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= max_val) return value;
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_monitor_if.sv
// Rate-sample valid/ready channel from the monitor to the readout logic.
interface spike_rate_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic [CNT_W-1:0] rate_count;
  logic             rate_valid;
  logic             out_ready;

  modport master (output rate_count, output rate_valid, input out_ready);
  modport slave  (input rate_count, input rate_valid, output out_ready);
endinterface

// File: rtl/spike_rate_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over inc).
module spike_sat_counter
  import spike_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    q_d = q;
    if (clear) begin
      q_d = '0;
    end else if (inc) begin
      q_d = WIDTH'(sat_inc(32'(q), WIDTH));
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_d;
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spike rising edges over back-to-back programmable windows and emits one rate
// sample per window on a valid/ready channel; flags dropped samples in a sticky overrun.
// Optional feature macro: SPIKE_ISI_EN (last inter-spike interval on isi_last).
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 spike_in,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 clr_overrun,
  spike_rate_monitor_if.master rate_if,
  output logic                 overrun,
  output logic [ISI_W-1:0]     isi_last
);

  state_e           state_q, state_d;
  logic             spike_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] rate_count_q, rate_count_d;
  logic             rate_valid_q, rate_valid_d;
  logic             overrun_q, overrun_d;
  logic             spike_event, in_count, last_cycle, win_end;

  assign spike_event = spike_in & ~spike_d;
  assign in_count    = (state_q == StCount);
  assign last_cycle  = (win_cnt_q == WIN_W'(1));
  // An abort on the last cycle discards the window like any other abort.
  assign win_end     = in_count & enable & last_cycle;
  assign result      = spike_event ? CNT_W'(sat_inc(32'(acc), CNT_W)) : acc;

  // Accumulator restarts at zero for every window; the closing cycle's event goes to result.
  spike_sat_counter #(.WIDTH(CNT_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~in_count | last_cycle),
    .inc   (in_count & spike_event),
    .q     (acc)
  );

  // FSM next state and window down-counter; a loaded 0 wraps to give 2**WIN_W cycles.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d   = StCount;
          win_cnt_d = window_len;
        end
      end
      StCount: begin
        if (!enable)         state_d   = StIdle;
        else if (last_cycle) win_cnt_d = window_len;
        else                 win_cnt_d = win_cnt_q - WIN_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Output handshake and overrun flag; a set beats a same-cycle clear.
  always_comb begin
    rate_count_d = rate_count_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;
    if (rate_valid_q && rate_if.out_ready) rate_valid_d = 1'b0;
    if (clr_overrun) overrun_d = 1'b0;
    if (win_end) begin
      if (!rate_valid_q || rate_if.out_ready) begin
        rate_count_d = result;
        rate_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      spike_d      <= 1'b0;
      win_cnt_q    <= '0;
      rate_count_q <= '0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_d      <= spike_in;
      win_cnt_q    <= win_cnt_d;
      rate_count_q <= rate_count_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_if.rate_count = rate_count_q;
  assign rate_if.rate_valid = rate_valid_q;
  assign overrun            = overrun_q;

`ifdef SPIKE_ISI_EN
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_last_q;
  logic             seen_q;

  // Cycles since the previous event; restarts on enable and after every event.
  spike_sat_counter #(.WIDTH(ISI_W)) u_isi (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~in_count | spike_event),
    .inc   (in_count),
    .q     (isi_cnt)
  );

  // Capture the edge-to-edge distance once a previous event exists since enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_last_q <= '0;
      seen_q     <= 1'b0;
    end else if (!in_count) begin
      seen_q <= 1'b0;
    end else if (spike_event) begin
      seen_q <= 1'b1;
      if (seen_q) isi_last_q <= (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
    end
  end

  assign isi_last = isi_last_q;
`else
  assign isi_last = '0;
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed self-checking bench for spike_rate_monitor (default 8-bit and a 4-bit count instance).
module tb_spike_rate_monitor;

`ifdef SPIKE_ISI_EN
  localparam bit IsiOn = 1'b1;
`else
  localparam bit IsiOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, spike_in, clr_overrun, overrun;
  logic [7:0] window_len, isi_last;
  logic       en2, spk2, clr2, ovr2;
  logic [7:0] wl2, isi2;

  int n_cmp = 0;
  int n_bad = 0;

  spike_rate_monitor_if #(.CNT_W(8)) rif ();
  spike_rate_monitor_if #(.CNT_W(4)) rif2 ();

  spike_rate_monitor #(.CNT_W(8), .WIN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .clr_overrun (clr_overrun),
    .rate_if     (rif),
    .overrun     (overrun),
    .isi_last    (isi_last)
  );

  spike_rate_monitor #(.CNT_W(4), .WIN_W(8)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en2),
    .spike_in    (spk2),
    .window_len  (wl2),
    .clr_overrun (clr2),
    .rate_if     (rif2),
    .overrun     (ovr2),
    .isi_last    (isi2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    enable   = 1'b0;
    spike_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic       saw_valid;
    logic [7:0] c8;
    rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0; window_len = 8'd10; clr_overrun = 1'b0;
    en2 = 1'b0; spk2 = 1'b0; wl2 = 8'd40; clr2 = 1'b0;
    rif.out_ready = 1'b1; rif2.out_ready = 1'b1;
    tick(); tick();
    check("rst_count", 32'(rif.rate_count), 0);
    check("rst_valid", 32'(rif.rate_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_isi", 32'(isi_last), 0);
    rst_n = 1'b1;
    tick();

    // 1: spikes in cycles 0,3,6,9 of a 10-cycle window.
    window_len = 8'd10; enable = 1'b1; tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c % 3 == 0);
      tick();
      if (c == 8) check("t1_pre_valid", 32'(rif.rate_valid), 0);
    end
    check("t1_valid", 32'(rif.rate_valid), 1);
    check("t1_count", 32'(rif.rate_count), 4);
    spike_in = 1'b0; tick();
    check("t1_valid_drop", 32'(rif.rate_valid), 0);
    go_idle();

    // 2: level held 20 cycles counts once.
    window_len = 8'd10; enable = 1'b1; tick();
    for (int c = 0; c < 20; c++) begin
      spike_in = 1'b1;
      tick();
      if (c == 9) check("t2_count_w1", 32'(rif.rate_count), 1);
    end
    check("t2_valid_w2", 32'(rif.rate_valid), 1);
    check("t2_count_w2", 32'(rif.rate_count), 0);
    go_idle();

    // 3: 4-bit accumulator saturates on 20 events.
    wl2 = 8'd40; en2 = 1'b1; tick();
    for (int c = 0; c < 40; c++) begin
      spk2 = (c % 2 == 0);
      tick();
    end
    check("t3_valid", 32'(rif2.rate_valid), 1);
    check("t3_sat_count", 32'(rif2.rate_count), 15);
    en2 = 1'b0; spk2 = 1'b0; tick();

    // 4: overrun with stalled consumer, then clear and drain.
    check("t4_pre_valid", 32'(rif.rate_valid), 0);
    rif.out_ready = 1'b0; window_len = 8'd5; enable = 1'b1; tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c == 1) || (c == 5) || (c == 7);
      tick();
      if (c == 4) begin
        check("t4_valid_w1", 32'(rif.rate_valid), 1);
        check("t4_ovr_w1", 32'(overrun), 0);
      end
    end
    check("t4_count_held", 32'(rif.rate_count), 1);
    check("t4_overrun", 32'(overrun), 1);
    enable = 1'b0; spike_in = 1'b0; clr_overrun = 1'b1; tick();
    check("t4_ovr_clr", 32'(overrun), 0);
    check("t4_valid_kept", 32'(rif.rate_valid), 1);
    clr_overrun = 1'b0; rif.out_ready = 1'b1; tick();
    check("t4_drained", 32'(rif.rate_valid), 0);
    tick();

    // 5a: abort in cycle 4, then a full fresh window.
    window_len = 8'd10; enable = 1'b1; tick();
    for (int c = 0; c < 5; c++) begin
      spike_in = (c == 1) || (c == 3);
      if (c == 4) enable = 1'b0;
      tick();
    end
    spike_in = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_valid = saw_valid | rif.rate_valid;
    end
    check("t5_abort_novalid", 32'(saw_valid), 0);
    enable = 1'b1; tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c == 2);
      tick();
      if (c == 8) check("t5_not_early", 32'(rif.rate_valid), 0);
    end
    check("t5_valid", 32'(rif.rate_valid), 1);
    check("t5_count", 32'(rif.rate_count), 1);
    go_idle();

    // 5b: asynchronous reset mid-window clears everything at once.
    rif.out_ready = 1'b0; window_len = 8'd3; enable = 1'b1; tick();
    for (int c = 0; c < 6; c++) begin
      spike_in = (c == 0) || (c == 3);
      tick();
    end
    check("t5_pre_rst_ovr", 32'(overrun), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_count", 32'(rif.rate_count), 0);
    check("t5_rst_valid", 32'(rif.rate_valid), 0);
    check("t5_rst_ovr", 32'(overrun), 0);
    enable = 1'b0; spike_in = 1'b0; rif.out_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();

    // 6: 256-cycle window (len 0) with ISI 7 then 300.
    window_len = 8'd0; enable = 1'b1; tick();
    for (int c = 0; c < 310; c++) begin
      spike_in = (c == 0) || (c == 7) || (c == 307);
      tick();
      c8 = IsiOn ? 8'd7 : 8'd0;
      if (c == 7) check("t6_isi7", 32'(isi_last), 32'(c8));
      if (c == 254) check("t6_win256_early", 32'(rif.rate_valid), 0);
      if (c == 255) begin
        check("t6_win256_valid", 32'(rif.rate_valid), 1);
        check("t6_win256_count", 32'(rif.rate_count), 2);
      end
      if (c == 306) check("t6_isi_hold", 32'(isi_last), 32'(c8));
      c8 = IsiOn ? 8'd255 : 8'd0;
      if (c == 307) check("t6_isi_sat", 32'(isi_last), 32'(c8));
    end
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
